seq_mult8x8: RTL and testbench

Sequential 8x8 unsigned multiplier built around the team's combinational 4x4 nibble multiplier (`vedic4x4`, 9-bit result). The block latches two 8-bit operands on a start request and feeds one nibble pair per cycle to a single `vedic4x4` instance over four cycles. It shifts and accumulates each 9-bit partial product into a 16-bit result and signals completion with a one-cycle `done` pulse. It sits between the operand source (register file or test harness) and any consumer of the 16-bit product.

---
 rtl/seq_mult8x8.sv | 144 ++++++++++++++
 tb/tb_seq_mult8x8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8x8.sv
// Sequential 8x8 unsigned multiplier: one 4x4 nibble multiplier, four
// steps per product, shift-and-accumulate into a 16-bit result.

// Combinational 4x4 multiplier built from four 2x2 vedic blocks.
module vedic4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [8:0] p
);
    function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
        logic t0, t1, t2, t3, c;
        t0 = u[0] & v[0];
        t1 = u[1] & v[0];
        t2 = u[0] & v[1];
        t3 = u[1] & v[1];
        c  = t1 & t2;
        return {t3 & c, t3 ^ c, t1 ^ t2, t0};
    endfunction

    logic [3:0] q_ll, q_hl, q_lh, q_hh;
    logic [8:0] mid;

    // Four 2x2 partial products combined with their nibble weights.
    always_comb begin
        q_ll = mul2(x[1:0], y[1:0]);
        q_hl = mul2(x[3:2], y[1:0]);
        q_lh = mul2(x[1:0], y[3:2]);
        q_hh = mul2(x[3:2], y[3:2]);
        mid  = {5'b0, q_hl} + {5'b0, q_lh};
        p    = {5'b0, q_ll} + (mid << 2) + ({5'b0, q_hh} << 4);
    end
endmodule

// State | meaning
// IDLE  | waiting for start; product holds last result
// RUN   | stepping through the four nibble pairs (step 0..3)
module seq_mult8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic [1:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nib_a, nib_b;
    logic [8:0]  pp;
    logic [15:0] pp_sh, sum;

    vedic4x4 u_vedic (
        .x (nib_a),
        .y (nib_b),
        .p (pp)
    );

    // Select the nibble pair and weight for the current step, then accumulate.
    always_comb begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        pp_sh = {7'b0, pp};
        case (step_q)
            2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; pp_sh = {7'b0, pp};       end
            2'd1: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; pp_sh = {7'b0, pp} << 4;  end
            2'd2: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; pp_sh = {7'b0, pp} << 4;  end
            default: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; pp_sh = {7'b0, pp} << 8; end
        endcase
        sum = acc_q + pp_sh;
    end

    // Next-state and datapath updates; everything holds unless a transition applies.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        step_d    = step_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step_q == 2'd3) begin
                    product_d = sum;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    step_d    = 2'd0;
                    state_d   = IDLE;
                end else begin
                    acc_d  = sum;
                    step_d = step_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            acc_q     <= 16'h0000;
            product_q <= 16'h0000;
            step_q    <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_mult8x8.sv
// Directed and random bench for seq_mult8x8.
module tb_seq_mult8x8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    int          done_cnt = 0;
    logic [15:0] prev_product = 16'h0000;

    seq_mult8x8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full directed run: accept, check busy/done every cycle, check result.
    task automatic run_directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] exp);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, {15'b0, busy}, 16'd1);
            check({tag, "_nodone"}, {15'b0, done}, 16'd0);
            if (i < 3) tick();
        end
        tick();
        check({tag, "_done"}, {15'b0, done}, 16'd1);
        check({tag, "_idle"}, {15'b0, busy}, 16'd0);
        check({tag, "_prod"}, product, exp);
        tick();
        check({tag, "_pulse"}, {15'b0, done}, 16'd0);
        check({tag, "_hold"}, product, exp);
    endtask

    // Wait for done within a bounded number of cycles.
    task automatic wait_done(input string tag, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 16'd0, 16'd1);
    endtask

    // Random-phase monitor: count done pulses and require product to hold between them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            else check("hold_between_done", product, prev_product);
            prev_product = product;
        end
    end

    initial begin
        logic        seen;
        int          ndone;
        logic [7:0]  ra, rb;
        logic [15:0] rexp;

        tick();
        tick();
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_done", {15'b0, done}, 16'd0);
        check("rst_prod", product, 16'h0000);
        rst_n = 1'b1;
        tick();

        run_directed("basic", 8'h12, 8'h34, 16'h03A8);
        run_directed("ffff", 8'hFF, 8'hFF, 16'hFE01);
        run_directed("a55a", 8'hA5, 8'h5A, 16'h3A02);
        run_directed("zero", 8'h00, 8'hC3, 16'h0000);
        run_directed("one", 8'h01, 8'h80, 16'h0080);

        // Back-to-back with start held high.
        a = 8'h0F;
        b = 8'h0F;
        start = 1'b1;
        tick();
        a = 8'hF0;
        b = 8'hF0;
        wait_done("b2b1", seen);
        check("b2b1_prod", product, 16'h00E1);
        tick();
        check("b2b_nogap_busy", {15'b0, busy}, 16'd1);
        check("b2b_nogap_done", {15'b0, done}, 16'd0);
        start = 1'b0;
        wait_done("b2b2", seen);
        check("b2b2_prod", product, 16'hE100);
        tick();

        // Start and operand change during RUN are ignored.
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        tick();
        a = 8'hFF;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            check("ign_busy", {15'b0, busy}, 16'd1);
            tick();
            start = 1'b0;
            if (done) ndone++;
        end
        check("ign_prod", product, 16'h0100);
        check("ign_busy_end", {15'b0, busy}, 16'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
        end
        check("ign_one_done", ndone[15:0], 16'd1);

        // Reset mid-operation.
        a = 8'h33;
        b = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", {15'b0, busy}, 16'd0);
        check("mrst_done", {15'b0, done}, 16'd0);
        check("mrst_prod", product, 16'h0000);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
        end
        check("mrst_no_done", ndone[15:0], 16'd0);
        run_directed("after_rst", 8'h33, 8'h33, 16'h0A29);

        // Random regression against a*b.
        prev_product = product;
        done_cnt = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rexp = 16'(ra) * 16'(rb);
            a = ra;
            b = rb;
            start = 1'b1;
            tick();
            start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            wait_done("rand", seen);
            if (seen) check("rand_prod", product, rexp);
        end
        tick();
        tick();
        mon_en = 1'b0;
        check("rand_done_count", done_cnt[15:0], 16'd10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
